// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: control-bit positions and the data-memory FSM state.
package mips_pkg;

    localparam int CTLM_BRANCH    = 2;
    localparam int CTLM_MEMREAD   = 1;
    localparam int CTLM_MEMWRITE  = 0;

    localparam int CTLWB_REGWRITE = 1;
    localparam int CTLWB_MEMTOREG = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB boundary register; a bubble retires the slot with its write-back controls cleared.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] alu_out_i,
    input  logic [1:0]  ctlwb_i,
    input  logic [4:0]  rd_i,
    output logic [31:0] rdata_o,
    output logic [31:0] alu_out_o,
    output logic [1:0]  ctlwb_o,
    output logic [4:0]  rd_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_o   <= '0;
            alu_out_o <= '0;
            ctlwb_o   <= '0;
            rd_o      <= '0;
        end else begin
            rdata_o   <= rdata_i;
            alu_out_o <= alu_out_i;
            ctlwb_o   <= bubble_i ? 2'b00 : ctlwb_i;
            rd_o      <= rd_i;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage of the MIPS core: req/ack data-memory access, branch resolve, stall and MEM/WB.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses and adds the align_err pulse.
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_bpc,
    input  logic [31:0] MEM_alu_out,
    input  logic [31:0] MEM_rd2,
    input  logic [1:0]  MEM_ctlwb,
    input  logic [2:0]  MEM_ctlm,
    input  logic        MEM_alu_zero,
    input  logic [4:0]  MEM_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        pcsrc,
    output logic [31:0] branch_pc,
    output logic        bus_err,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        align_err,
`endif
    output logic [31:0] WB_rdata,
    output logic [31:0] WB_alu_out,
    output logic [1:0]  WB_ctlwb,
    output logic [4:0]  WB_rd
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    mem_state_e  state_q;
    logic [15:0] cnt_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        we_q, to_q, bus_err_q;
    logic        memop, misalign, start, bubble;

    assign memop = MEM_ctlm[CTLM_MEMREAD] | MEM_ctlm[CTLM_MEMWRITE];
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = memop & (MEM_alu_out[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign start  = (state_q == IDLE) & memop & ~misalign;
    assign stall  = start | (state_q == REQ);
    // A timed-out or rejected access still retires, but must not write back.
    assign bubble = stall | ((state_q == DONE) & to_q) | ((state_q == IDLE) & misalign);

    assign pcsrc      = MEM_ctlm[CTLM_BRANCH] & MEM_alu_zero;
    assign branch_pc  = MEM_bpc;
    assign dmem_req   = (state_q == REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign bus_err    = bus_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            we_q      <= 1'b0;
            to_q      <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= REQ;
                    cnt_q   <= '0;
                    addr_q  <= {MEM_alu_out[31:2], 2'b00};
                    wdata_q <= MEM_rd2;
                    we_q    <= MEM_ctlm[CTLM_MEMWRITE];
                    to_q    <= 1'b0;
                end
                // Ack takes priority over a timeout landing on the same cycle.
                REQ: if (dmem_ack) begin
                    state_q <= DONE;
                    rdata_q <= dmem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_q   <= DONE;
                    rdata_q   <= '0;
                    to_q      <= 1'b1;
                    bus_err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) align_err <= 1'b0;
        else     align_err <= (state_q == IDLE) & misalign;
    end
`endif

    mem_wb_reg u_mem_wb_reg (
        .clk       (clk),
        .rst       (rst),
        .bubble_i  (bubble),
        .rdata_i   (rdata_q),
        .alu_out_i (MEM_alu_out),
        .ctlwb_i   (MEM_ctlwb),
        .rd_i      (MEM_rd),
        .rdata_o   (WB_rdata),
        .alu_out_o (WB_alu_out),
        .ctlwb_o   (WB_ctlwb),
        .rd_o      (WB_rd)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed and randomized checks of mem_stage_ctrl against a per-instruction latency/result model.
module tb_mem_stage_ctrl;

    localparam int T = 4;

    logic        clk, rst;
    logic [31:0] MEM_bpc, MEM_alu_out, MEM_rd2, dmem_rdata;
    logic [1:0]  MEM_ctlwb;
    logic [2:0]  MEM_ctlm;
    logic        MEM_alu_zero, dmem_ack;
    logic [4:0]  MEM_rd;
    logic        dmem_req, dmem_we, stall, pcsrc, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, branch_pc, WB_rdata, WB_alu_out;
    logic [1:0]  WB_ctlwb;
    logic [4:0]  WB_rd;

    int checks = 0;
    int errors = 0;
    logic buserr_m = 1'b0;

    mem_stage_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst),
        .MEM_bpc(MEM_bpc), .MEM_alu_out(MEM_alu_out), .MEM_rd2(MEM_rd2),
        .MEM_ctlwb(MEM_ctlwb), .MEM_ctlm(MEM_ctlm), .MEM_alu_zero(MEM_alu_zero), .MEM_rd(MEM_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .pcsrc(pcsrc), .branch_pc(branch_pc), .bus_err(bus_err),
        .WB_rdata(WB_rdata), .WB_alu_out(WB_alu_out), .WB_ctlwb(WB_ctlwb), .WB_rd(WB_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one instruction, hold it while stalled (frozen EX/MEM), answer the bus
    // after 'delay' unacknowledged REQ cycles, then check the retired MEM/WB contents.
    task automatic run_instr(input logic [2:0] ctlm, input logic [1:0] ctlwb,
                             input logic [31:0] alu, input logic [31:0] wd,
                             input logic [4:0] rd, input logic [31:0] bpc,
                             input logic zero, input int delay, input logic [31:0] rdat);
        logic memop, timeout, st, done;
        int   exp_req, nreq, nstall;
        memop   = ctlm[1] | ctlm[0];
        timeout = memop && (delay >= T);
        exp_req = !memop ? 0 : (timeout ? T : delay + 1);
        nreq = 0; nstall = 0; done = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            MEM_ctlm = ctlm; MEM_ctlwb = ctlwb; MEM_alu_out = alu; MEM_rd2 = wd;
            MEM_rd = rd; MEM_bpc = bpc; MEM_alu_zero = zero;
            if (dmem_req) begin
                chk("req_addr", dmem_addr, {alu[31:2], 2'b00});
                chk("req_we", dmem_we, ctlm[0]);
                chk("req_wdata", dmem_wdata, wd);
                dmem_ack   = (nreq == delay);
                dmem_rdata = dmem_ack ? rdat : $urandom;
                nreq++;
            end else begin
                dmem_ack   = ($urandom_range(0, 3) == 0);
                dmem_rdata = $urandom;
            end
            #1;
            chk("pcsrc", pcsrc, ctlm[2] & zero);
            chk("branch_pc", branch_pc, bpc);
            st = stall;
            if (st) nstall++;
            @(posedge clk); #1;
            if (st) chk("bubble_ctlwb", WB_ctlwb, 2'b00);
            else    done = 1'b1;
        end
        if (!done) chk("retire_bound", 32'd0, 32'd1);
        if (timeout) buserr_m = 1'b1;
        chk("stall_cycles", nstall, memop ? exp_req + 1 : 0);
        chk("req_cycles", nreq, exp_req);
        chk("wb_alu_out", WB_alu_out, alu);
        chk("wb_rd", WB_rd, rd);
        chk("wb_ctlwb", WB_ctlwb, timeout ? 2'b00 : ctlwb);
        if (ctlm[1:0] == 2'b10) chk("wb_rdata", WB_rdata, timeout ? 32'd0 : rdat);
        chk("bus_err", bus_err, buserr_m);
    endtask

    initial begin
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
        MEM_bpc = '0; MEM_alu_out = '0; MEM_rd2 = '0; MEM_ctlwb = '0;
        MEM_ctlm = '0; MEM_alu_zero = 1'b0; MEM_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_buserr", bus_err, 1'b0);
        chk("rst_wb_alu", WB_alu_out, 32'd0);
        chk("rst_wb_rdata", WB_rdata, 32'd0);
        chk("rst_wb_ctl", {25'd0, WB_rd, WB_ctlwb}, 32'd0);
        @(negedge clk); rst = 1'b0;

        run_instr(3'b000, 2'b10, 32'h1234, 32'h0, 5'd5, 32'h0, 1'b0, 0, 32'h0);
        run_instr(3'b010, 2'b11, 32'h100, 32'h0, 5'd8, 32'h0, 1'b0, 3, 32'hDEADBEEF);
        run_instr(3'b001, 2'b00, 32'h200, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b0, 1, 32'h0);
        run_instr(3'b010, 2'b11, 32'h300, 32'h0, 5'd9, 32'h0, 1'b0, 1000, 32'h12345678);
        run_instr(3'b100, 2'b00, 32'h0, 32'h0, 5'd0, 32'h40, 1'b1, 0, 32'h0);
        run_instr(3'b100, 2'b00, 32'h1, 32'h0, 5'd0, 32'h40, 1'b0, 0, 32'h0);
        run_instr(3'b011, 2'b01, 32'h404, 32'h77, 5'd3, 32'h0, 1'b0, 0, 32'h5);

        for (int i = 0; i < 40; i++)
            run_instr(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                      5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 5), $urandom);

        // Reset in the middle of an access abandons it and clears sticky state.
        @(negedge clk);
        MEM_ctlm = 3'b010; MEM_ctlwb = 2'b11; MEM_alu_out = 32'h500; MEM_rd = 5'd4; dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_req_active", dmem_req, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        buserr_m = 1'b0;
        chk("mid_rst_req", dmem_req, 1'b0);
        chk("mid_rst_buserr", bus_err, buserr_m);
        chk("mid_rst_wb_alu", WB_alu_out, 32'd0);
        chk("mid_rst_wb_rdata", WB_rdata, 32'd0);
        chk("mid_rst_wb_ctl", {25'd0, WB_rd, WB_ctlwb}, 32'd0);
        @(negedge clk); rst = 1'b0; MEM_ctlm = 3'b000;
        #1;
        chk("mid_rst_idle_stall", stall, 1'b0);
        @(posedge clk); #1;
        chk("mid_rst_idle_req", dmem_req, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
